// File: rtl/gen_linebuf_addr.sv
// Line-buffer address generator: write/read pixel addresses, one-hot bank rotation,
// line occupancy accounting with sticky overrun/underrun, and per-frame line counting.
module gen_linebuf_addr #(
   parameter int ADDR_W      = 11,
   parameter int LINE_LEN    = 1280,
   parameter int NUM_BANKS   = 2,
   parameter int FRAME_LINES = 1024,
   parameter int LCNT_W      = 11
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 sof,
   input  logic                 wr_en,
   input  logic                 rd_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [NUM_BANKS-1:0] wr_bank,
   output logic [ADDR_W-1:0]    rd_addr,
   output logic [NUM_BANKS-1:0] rd_bank,
   output logic [2:0]           lines_avail,
   output logic                 line_done,
   output logic                 frame_done,
   output logic [LCNT_W-1:0]    wr_line_cnt,
   output logic                 overrun,
   output logic                 underrun
);

   localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(LINE_LEN - 1);
   localparam logic [2:0]           AVAIL_MAX = 3'(NUM_BANKS);
   localparam logic [LCNT_W-1:0]    CNT_LAST  = LCNT_W'(FRAME_LINES - 1);
   localparam logic [NUM_BANKS-1:0] BANK_0    = NUM_BANKS'(1);

   function automatic logic [NUM_BANKS-1:0] rotl(input logic [NUM_BANKS-1:0] b);
      return {b[NUM_BANKS-2:0], b[NUM_BANKS-1]};
   endfunction

   logic       wr_wrap_s;
   logic       rd_ok_s;
   logic       rd_wrap_s;
   logic       ovr_evt_s;
   logic [2:0] avail_next_s;

   // Completion strobes and next occupancy; a full buffer keeps its count on overwrite.
   always_comb begin
      wr_wrap_s    = wr_en && (wr_addr == ADDR_LAST);
      rd_ok_s      = rd_en && (lines_avail != 3'd0);
      rd_wrap_s    = rd_ok_s && (rd_addr == ADDR_LAST);
      ovr_evt_s    = 1'b0;
      avail_next_s = lines_avail;
      if (wr_wrap_s && !rd_wrap_s) begin
         if (lines_avail == AVAIL_MAX) begin
            ovr_evt_s = 1'b1;
         end else begin
            avail_next_s = lines_avail + 3'd1;
         end
      end else if (rd_wrap_s && !wr_wrap_s) begin
         avail_next_s = lines_avail - 3'd1;
      end else begin
         avail_next_s = lines_avail;
      end
   end

   // State registers; sof overrides any enable in the same cycle.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         wr_addr     <= '0;
         rd_addr     <= '0;
         wr_bank     <= BANK_0;
         rd_bank     <= BANK_0;
         lines_avail <= 3'd0;
         wr_line_cnt <= '0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else if (sof) begin
         wr_addr     <= '0;
         rd_addr     <= '0;
         wr_bank     <= BANK_0;
         rd_bank     <= BANK_0;
         lines_avail <= 3'd0;
         wr_line_cnt <= '0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         if (wr_wrap_s) begin
            wr_addr <= '0;
            wr_bank <= rotl(wr_bank);
         end else if (wr_en) begin
            wr_addr <= wr_addr + ADDR_W'(1);
         end
         if (rd_wrap_s) begin
            rd_addr <= '0;
            rd_bank <= rotl(rd_bank);
         end else if (rd_ok_s) begin
            rd_addr <= rd_addr + ADDR_W'(1);
         end
         if (wr_wrap_s) begin
            wr_line_cnt <= (wr_line_cnt == CNT_LAST) ? '0 : wr_line_cnt + LCNT_W'(1);
         end
         lines_avail <= avail_next_s;
         line_done   <= wr_wrap_s;
         frame_done  <= wr_wrap_s && (wr_line_cnt == CNT_LAST);
         overrun     <= overrun | ovr_evt_s;
         underrun    <= underrun | (rd_en && (lines_avail == 3'd0));
      end
   end

endmodule

// File: tb/tb_gen_linebuf_addr.sv
// Bench for gen_linebuf_addr: 2-bank and 4-bank instances driven in parallel and
// compared every cycle against a pixel/line counting model.
module tb_gen_linebuf_addr;
   localparam int LL = 12;
   localparam int FL = 10;

   logic clk = 1'b0;
   logic aclr = 1'b0;
   logic sof = 1'b0;
   logic wr_en = 1'b0;
   logic rd_en = 1'b0;

   logic [10:0] wa0, ra0, wa1, ra1;
   logic [1:0]  wb0, rb0;
   logic [3:0]  wb1, rb1;
   logic [2:0]  av0, av1;
   logic        ld0, fd0, ov0, un0, ld1, fd1, ov1, un1;
   logic [10:0] lc0, lc1;

   int tests = 0;
   int fails = 0;

   gen_linebuf_addr #(.ADDR_W(11), .LINE_LEN(LL), .NUM_BANKS(2), .FRAME_LINES(FL), .LCNT_W(11)) dut2 (
      .clk(clk), .aclr(aclr), .sof(sof), .wr_en(wr_en), .rd_en(rd_en),
      .wr_addr(wa0), .wr_bank(wb0), .rd_addr(ra0), .rd_bank(rb0), .lines_avail(av0),
      .line_done(ld0), .frame_done(fd0), .wr_line_cnt(lc0), .overrun(ov0), .underrun(un0));

   gen_linebuf_addr #(.ADDR_W(11), .LINE_LEN(LL), .NUM_BANKS(4), .FRAME_LINES(FL), .LCNT_W(11)) dut4 (
      .clk(clk), .aclr(aclr), .sof(sof), .wr_en(wr_en), .rd_en(rd_en),
      .wr_addr(wa1), .wr_bank(wb1), .rd_addr(ra1), .rd_bank(rb1), .lines_avail(av1),
      .line_done(ld1), .frame_done(fd1), .wr_line_cnt(lc1), .overrun(ov1), .underrun(un1));

   always #5 clk = ~clk;

   // Model: pixel positions, bank indices and line counts as plain integers.
   int nb[2] = '{2, 4};
   int m_wa[2], m_ra[2], m_wbi[2], m_rbi[2], m_av[2], m_cnt[2];
   bit m_ld[2], m_fd[2], m_ov[2], m_un[2];

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_wa[k] = 0; m_ra[k] = 0; m_wbi[k] = 0; m_rbi[k] = 0; m_av[k] = 0; m_cnt[k] = 0;
         m_ld[k] = 0; m_fd[k] = 0; m_ov[k] = 0; m_un[k] = 0;
      end
   endtask

   task automatic model_step(input bit s, input bit w, input bit r);
      bit wc, acc, rc;
      for (int k = 0; k < 2; k++) begin
         if (s) begin
            m_wa[k] = 0; m_ra[k] = 0; m_wbi[k] = 0; m_rbi[k] = 0; m_av[k] = 0; m_cnt[k] = 0;
            m_ld[k] = 0; m_fd[k] = 0; m_ov[k] = 0; m_un[k] = 0;
         end else begin
            wc  = w && (m_wa[k] == LL - 1);
            acc = r && (m_av[k] > 0);
            rc  = acc && (m_ra[k] == LL - 1);
            if (r && m_av[k] == 0) m_un[k] = 1;
            if (w) m_wa[k] = (m_wa[k] + 1) % LL;
            if (acc) m_ra[k] = (m_ra[k] + 1) % LL;
            if (wc) m_wbi[k] = (m_wbi[k] + 1) % nb[k];
            if (rc) m_rbi[k] = (m_rbi[k] + 1) % nb[k];
            if (wc && !rc) begin
               if (m_av[k] == nb[k]) m_ov[k] = 1;
               else m_av[k] = m_av[k] + 1;
            end else if (rc && !wc) begin
               m_av[k] = m_av[k] - 1;
            end
            m_ld[k] = wc;
            m_fd[k] = wc && (m_cnt[k] + 1 == FL);
            if (wc) m_cnt[k] = (m_cnt[k] + 1) % FL;
         end
      end
   endtask

   task automatic chk(input string tag, input int k, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s inst%0d: observed %0d expected %0d", tag, nb[k], obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wr_addr"}, 0, int'(wa0), m_wa[0]);
      chk({tag, ".rd_addr"}, 0, int'(ra0), m_ra[0]);
      chk({tag, ".wr_bank"}, 0, int'(wb0), 1 << m_wbi[0]);
      chk({tag, ".rd_bank"}, 0, int'(rb0), 1 << m_rbi[0]);
      chk({tag, ".avail"},   0, int'(av0), m_av[0]);
      chk({tag, ".line_done"}, 0, int'(ld0), int'(m_ld[0]));
      chk({tag, ".frame_done"}, 0, int'(fd0), int'(m_fd[0]));
      chk({tag, ".line_cnt"}, 0, int'(lc0), m_cnt[0]);
      chk({tag, ".overrun"}, 0, int'(ov0), int'(m_ov[0]));
      chk({tag, ".underrun"}, 0, int'(un0), int'(m_un[0]));
      chk({tag, ".wr_addr"}, 1, int'(wa1), m_wa[1]);
      chk({tag, ".rd_addr"}, 1, int'(ra1), m_ra[1]);
      chk({tag, ".wr_bank"}, 1, int'(wb1), 1 << m_wbi[1]);
      chk({tag, ".rd_bank"}, 1, int'(rb1), 1 << m_rbi[1]);
      chk({tag, ".avail"},   1, int'(av1), m_av[1]);
      chk({tag, ".line_done"}, 1, int'(ld1), int'(m_ld[1]));
      chk({tag, ".frame_done"}, 1, int'(fd1), int'(m_fd[1]));
      chk({tag, ".line_cnt"}, 1, int'(lc1), m_cnt[1]);
      chk({tag, ".overrun"}, 1, int'(ov1), int'(m_ov[1]));
      chk({tag, ".underrun"}, 1, int'(un1), int'(m_un[1]));
   endtask

   int fd_seen;

   task automatic cycle(input string tag, input bit s, input bit w, input bit r);
      sof = s; wr_en = w; rd_en = r;
      @(posedge clk);
      model_step(s, w, r);
      #1;
      if (fd0) fd_seen++;
      check_all(tag);
   endtask

   initial begin
      model_clear();
      fd_seen = 0;
      #23;
      check_all("reset");
      aclr = 1'b1;

      // Write one full line
      for (int i = 0; i < LL; i++) cycle("wrline", 1'b0, 1'b1, 1'b0);
      chk("wrline.bank_const", 0, int'(wb0), 2);
      chk("wrline.avail_const", 0, int'(av0), 1);
      cycle("wrline_tail", 1'b0, 1'b0, 1'b0);

      // Underrun from a clean start, then read gating
      cycle("sof", 1'b1, 1'b0, 1'b0);
      cycle("underrun", 1'b0, 1'b0, 1'b1);
      chk("underrun.const", 0, int'(un0), 1);
      for (int i = 0; i < LL; i++) cycle("wr1", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < LL; i++) cycle("rd1", 1'b0, 1'b0, 1'b1);
      chk("rd1.rd_bank_const", 0, int'(rb0), 2);

      // Overrun: three lines, no reads
      cycle("sof", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3 * LL; i++) cycle("ovr", 1'b0, 1'b1, 1'b0);
      chk("ovr.const", 0, int'(ov0), 1);

      // Frame: 120 writes with matching reads, simultaneous wraps in the middle
      cycle("sof", 1'b1, 1'b0, 1'b0);
      fd_seen = 0;
      for (int i = 0; i < LL; i++) cycle("frm_w", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 108; i++) cycle("frm_wr", 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < LL; i++) cycle("frm_r", 1'b0, 1'b0, 1'b1);
      chk("frame_done_count", 0, fd_seen, 1);

      // sof mid-line together with wr_en
      cycle("sof", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LL; i++) cycle("mid_w", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle("mid_wr", 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) cycle("mid_w2", 1'b0, 1'b1, 1'b0);
      chk("mid.wr_addr_const", 0, int'(wa0), 5);
      chk("mid.rd_addr_const", 0, int'(ra0), 3);
      cycle("sof_mid", 1'b1, 1'b1, 1'b1);

      // Asynchronous clear mid-line, no clock edge involved
      for (int i = 0; i < 7; i++) cycle("pre_aclr", 1'b0, 1'b1, 1'b0);
      sof = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      #2 aclr = 1'b0;
      #1 model_clear();
      check_all("aclr_async");
      #1 aclr = 1'b1;

      // Four-bank rotation over five lines
      for (int i = 0; i < 5 * LL; i++) cycle("rot4", 1'b0, 1'b1, 1'b0);

      // Randomized traffic with occasional sof
      for (int i = 0; i < 600; i++) begin
         cycle("rand", ($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
